fetch_stage: RTL and testbench

Instruction fetch stage with IF/ID pipeline register; it sits directly upstream of the decoder. It owns the program counter and issues instruction-memory reads through a valid/ready request with an in-order response. It presents `{pc, inst, valid}` to the decoder and honours stall from the hazard logic and redirect (taken branch/jump) from EX. A one-entry hold buffer guarantees no fetched word is lost while ID is stalled.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_hold_buf.sv | 33 +++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage and its hold buffer.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2
    } if_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: valid/ready request, in-order response, one outstanding.
interface fetch_stage_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, inst} holding buffer; flush beats write, write beats read.
module fetch_hold_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_inst,
    input  logic        rd,
    input  logic        flush,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            pc   <= '0;
            inst <= NOP_INST;
        end else if (flush) begin
            full <= 1'b0;
        end else if (wr) begin
            full <= 1'b1;
            pc   <= wr_pc;
            inst <= wr_inst;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the pc, issues imem reads and drives the IF/ID register.
//
// state   | meaning
// --------+--------------------------------------------------
// IF_IDLE | no request outstanding
// IF_WAIT | one request accepted, response pending
// IF_DROP | response pending but stale after a redirect
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 id_valid,
    output logic [31:0]          id_inst,
    output logic [31:0]          id_pc
);

    if_state_t   state;
    logic [31:0] pc;
    logic [31:0] req_pc;

    logic        buf_full;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;

    logic        req_fire;
    logic        rsp_take;
    logic        load_id;
    logic        buf_wr;
    logic        buf_rd;

    // In WAIT the next request rides on the current response so zero-wait memory sustains 1 instr/cycle.
    assign imem.addr      = pc;
    assign imem.req_valid = (state == IF_IDLE) ? (rst_n && !buf_full) :
                            (state == IF_WAIT) ? (imem.rsp_valid && !(id_valid && stall)) :
                            1'b0;

    assign req_fire = imem.req_valid && imem.req_ready;
    assign rsp_take = (state == IF_WAIT) && imem.rsp_valid && !redirect;
    assign load_id  = rsp_take && (!id_valid || !stall);
    assign buf_wr   = rsp_take && id_valid && stall;
    assign buf_rd   = !redirect && !stall && buf_full;

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (buf_wr),
        .wr_pc   (req_pc),
        .wr_inst (imem.rsp_data),
        .rd      (buf_rd),
        .flush   (redirect),
        .full    (buf_full),
        .pc      (buf_pc),
        .inst    (buf_inst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IF_IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= '0;
        end else begin
            if (req_fire) begin
                req_pc <= pc;
            end

            if (redirect) begin
                pc       <= align_word(redirect_pc);
                id_valid <= 1'b0;
                id_inst  <= NOP_INST;
                // A request accepted now, or one still unanswered, belongs to the old path.
                if (req_fire) begin
                    state <= IF_DROP;
                end else if (state != IF_IDLE && !imem.rsp_valid) begin
                    state <= IF_DROP;
                end else begin
                    state <= IF_IDLE;
                end
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end

                if (load_id) begin
                    id_valid <= 1'b1;
                    id_inst  <= imem.rsp_data;
                    id_pc    <= req_pc;
                end else if (buf_rd) begin
                    id_valid <= 1'b1;
                    id_inst  <= buf_inst;
                    id_pc    <= buf_pc;
                end else if (!stall) begin
                    id_valid <= 1'b0;
                    id_inst  <= NOP_INST;
                end

                case (state)
                    IF_IDLE: begin
                        if (req_fire) begin
                            state <= IF_WAIT;
                        end
                    end
                    IF_WAIT: begin
                        if (imem.rsp_valid) begin
                            state <= req_fire ? IF_WAIT : IF_IDLE;
                        end
                    end
                    IF_DROP: begin
                        if (imem.rsp_valid) begin
                            state <= IF_IDLE;
                        end
                    end
                    default: state <= IF_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model pushes fetched words, the ID-side monitor pops them.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    logic        id_valid2;
    logic [31:0] id_inst2;
    logic [31:0] id_pc2;

    int errors = 0;
    int checks = 0;

    logic        ready_cfg = 1'b0;
    int          mem_lat = 1;
    logic [63:0] sb_q[$];

    fetch_stage_if imem();
    fetch_stage_if imem2();

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem2),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .id_valid    (id_valid2),
        .id_inst     (id_inst2),
        .id_pc       (id_pc2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: fixed latency, pushes each accepted non-stale request to the scoreboard.
    initial begin : mem_model
        logic        pend;
        logic [31:0] pend_addr;
        int          pend_cnt;
        logic        hs;
        logic [31:0] hs_addr;
        logic        hs_redir;
        pend = 1'b0;
        pend_addr = '0;
        pend_cnt = 0;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (pend && pend_cnt <= 1) begin
                imem.rsp_valid = 1'b1;
                imem.rsp_data  = memword(pend_addr);
            end else begin
                imem.rsp_valid = 1'b0;
                if (pend) pend_cnt--;
            end
            #1;
            imem.req_ready = ready_cfg;
            hs       = imem.req_valid && imem.req_ready;
            hs_addr  = imem.addr;
            hs_redir = redirect;
            @(posedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (imem.rsp_valid) pend = 1'b0;
                if (hs) begin
                    pend      = 1'b1;
                    pend_addr = hs_addr;
                    pend_cnt  = mem_lat;
                    if (!hs_redir) sb_q.push_back({hs_addr, memword(hs_addr)});
                end
            end
        end
    end

    // ID-side monitor: consumes an instruction whenever ID is not stalled.
    initial begin : id_monitor
        logic        prev_hold;
        logic [64:0] prev_id;
        logic [63:0] exp;
        prev_hold = 1'b0;
        prev_id = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (prev_hold) begin
                    checks++;
                    if ({id_valid, id_inst, id_pc} !== prev_id) begin
                        errors++;
                        $display("FAIL stall_hold: id=%h required %h", {id_valid, id_inst, id_pc}, prev_id);
                    end
                end
                if (!id_valid) begin
                    checks++;
                    if (id_inst !== NOP_INST) begin
                        errors++;
                        $display("FAIL nop_when_invalid: id_inst=%h required %h", id_inst, NOP_INST);
                    end
                end
                if (redirect) begin
                    sb_q.delete();
                end else if (id_valid && !stall) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: id_pc=%h id_inst=%h required no instruction", id_pc, id_inst);
                    end else begin
                        exp = sb_q.pop_front();
                        if ({id_pc, id_inst} !== exp) begin
                            errors++;
                            $display("FAIL sb_order: pc/inst=%h/%h required %h/%h", id_pc, id_inst, exp[63:32], exp[31:0]);
                        end
                    end
                end
                prev_hold = stall && !redirect && id_valid;
                prev_id   = {id_valid, id_inst, id_pc};
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({imem.req_valid, id_valid, id_inst, id_pc} !== {1'b0, 1'b0, NOP_INST, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: req_valid=%b id_valid=%b id_inst=%h id_pc=%h required 0 0 %h 0",
                     imem.req_valid, id_valid, id_inst, id_pc, NOP_INST);
        end
        checks++;
        if (imem2.req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req2: req_valid=%b required 0", imem2.req_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem.req_valid !== 1'b1 || imem.addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req_valid=%b addr=%h required 1 00000000", imem.req_valid, imem.addr);
        end
    endtask

    task automatic test_stream();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) ready_cfg = 1'b1;
            #1;
            if (c >= 3) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'(4 * (c - 3))) begin
                    errors++;
                    $display("FAIL stream_c%0d: id_valid=%b id_pc=%h required 1 %h", c, id_valid, id_pc, 32'(4 * (c - 3)));
                end
            end
        end
        @(negedge clk);
        ready_cfg = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stall();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            redirect    = (c == 0);
            redirect_pc = 32'h0;
            ready_cfg   = (c >= 1);
            stall       = (c >= 4 && c <= 6);
            #1;
            if (c == 4) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'h4 || imem.req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_enter: id_valid=%b id_pc=%h req_valid=%b required 1 4 0", id_valid, id_pc, imem.req_valid);
                end
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (id_pc !== 32'h4 || dut.u_hold.full !== 1'b1 || imem.req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_c%0d: id_pc=%h buf_full=%b req_valid=%b required 4 1 0",
                             c, id_pc, dut.u_hold.full, imem.req_valid);
                end
            end
            if (c == 8) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'h8) begin
                    errors++;
                    $display("FAIL stall_drain: id_valid=%b id_pc=%h required 1 8", id_valid, id_pc);
                end
            end
            if (c == 10) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'hC) begin
                    errors++;
                    $display("FAIL stall_next: id_valid=%b id_pc=%h required 1 c", id_valid, id_pc);
                end
            end
        end
        @(negedge clk);
        ready_cfg = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            ready_cfg   = (c == 0) || (c >= 4);
            redirect    = (c == 1);
            redirect_pc = 32'h0000_0101;
            #1;
            if (c == 2 || c == 3) begin
                checks++;
                if (id_valid !== 1'b0 || imem.req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_drop_c%0d: id_valid=%b req_valid=%b required 0 0", c, id_valid, imem.req_valid);
                end
            end
            if (c == 4) begin
                checks++;
                if (imem.req_valid !== 1'b1 || imem.addr !== 32'h100) begin
                    errors++;
                    $display("FAIL redir_addr: req_valid=%b addr=%h required 1 00000100", imem.req_valid, imem.addr);
                end
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_gap_c%0d: id_valid=%b required 0", c, id_valid);
                end
            end
            if (c == 8) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== memword(32'h100)) begin
                    errors++;
                    $display("FAIL redir_target: id_valid=%b id_pc=%h id_inst=%h required 1 100 %h",
                             id_valid, id_pc, id_inst, memword(32'h100));
                end
            end
        end
        @(negedge clk);
        ready_cfg = 1'b0;
        redirect  = 1'b0;
        repeat (6) @(negedge clk);
        mem_lat = 1;
    endtask

    task automatic test_redirect_rsp_stall();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            stall       = (c == 2);
            redirect    = (c == 2);
            redirect_pc = 32'h0000_0203;
            ready_cfg   = (c != 2);
            #1;
            if (c == 2) begin
                checks++;
                if (id_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rsp_stall_pre: id_valid=%b required 1", id_valid);
                end
            end
            if (c == 3) begin
                checks++;
                if (id_valid !== 1'b0 || dut.u_hold.full !== 1'b0 || imem.req_valid !== 1'b1 || imem.addr !== 32'h200) begin
                    errors++;
                    $display("FAIL rsp_stall_flush: id_valid=%b buf_full=%b req_valid=%b addr=%h required 0 0 1 00000200",
                             id_valid, dut.u_hold.full, imem.req_valid, imem.addr);
                end
            end
            if (c == 5) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
                    errors++;
                    $display("FAIL rsp_stall_target: id_valid=%b id_pc=%h required 1 200", id_valid, id_pc);
                end
            end
        end
        @(negedge clk);
        ready_cfg = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending=%0d required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_pc_wrap();
        logic [31:0] exp_addr [3];
        logic        p2;
        logic [31:0] pa2;
        logic        h2;
        logic [31:0] a2;
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        p2  = 1'b0;
        pa2 = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            imem2.rsp_valid = p2;
            imem2.rsp_data  = memword(pa2);
            imem2.req_ready = 1'b1;
            #1;
            if (c < 3) begin
                checks++;
                if (imem2.req_valid !== 1'b1 || imem2.addr !== exp_addr[c]) begin
                    errors++;
                    $display("FAIL wrap_addr_%0d: req_valid=%b addr=%h required 1 %h", c, imem2.req_valid, imem2.addr, exp_addr[c]);
                end
            end
            if (c >= 2) begin
                checks++;
                if (id_valid2 !== 1'b1 || id_pc2 !== exp_addr[c-2] || id_inst2 !== memword(exp_addr[c-2])) begin
                    errors++;
                    $display("FAIL wrap_id_%0d: id_valid=%b id_pc=%h required 1 %h", c, id_valid2, id_pc2, exp_addr[c-2]);
                end
            end
            h2 = imem2.req_valid;
            a2 = imem2.addr;
            @(posedge clk);
            p2  = h2;
            pa2 = a2;
        end
        @(negedge clk);
        imem2.req_ready = 1'b0;
        imem2.rsp_valid = 1'b0;
    endtask

    initial begin
        imem2.req_ready = 1'b0;
        imem2.rsp_valid = 1'b0;
        imem2.rsp_data  = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp_stall();
        test_reset_pc_wrap();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
